seq_divider16: RTL and testbench

//  Multi-cycle unsigned restoring divider. It is the inverse companion of the

---
 rtl/seqdiv_pkg.sv | 19 +
 rtl/seq_divider16_sub_lookahead.sv | 67 ++++++
 rtl/seq_divider16.sv | 143 ++++++++++++++
 tb/tb_seq_divider16.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/seqdiv_pkg.sv
// ============================================================================
// seqdiv_pkg : shared FSM state type and default width for seq_divider16
// Revision   : 1.0
// ============================================================================
`default_nettype none

package seqdiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqdiv_state_t;

    localparam int SEQDIV_W_DEFAULT = 16;

endpackage

`default_nettype wire

// File: rtl/seq_divider16_sub_lookahead.sv
// ============================================================================
// sub_lookahead : combinational a - b as a + ~b + 1 with 4-bit group lookahead
// Revision      : 1.0
// ============================================================================
`default_nettype none

module sub_lookahead #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int NG = (N + 3) / 4;
    localparam int NP = NG * 4;

    // Padding b with zeros before inversion makes the carry out of NP bits
    // equal to (a >= b), so borrow is simply its complement.
    logic [NP-1:0] w_x;
    logic [NP-1:0] w_y;
    logic [NP-1:0] w_g;
    logic [NP-1:0] w_p;
    logic [NP-1:0] w_c;
    logic [NP-1:0] w_s;
    logic [NG:0]   w_gc;
    logic          w_unused;

    assign w_x     = NP'(a);
    assign w_y     = ~(NP'(b));
    assign w_g     = w_x & w_y;
    assign w_p     = w_x ^ w_y;
    assign w_gc[0] = 1'b1;

    for (genvar i = 0; i < NG; i++) begin : g_grp
        logic [3:0] w_gi;
        logic [3:0] w_pi;
        logic       w_cin;
        logic       w_ggen;
        logic       w_gprop;

        assign w_gi    = w_g[4*i +: 4];
        assign w_pi    = w_p[4*i +: 4];
        assign w_cin   = w_gc[i];
        assign w_ggen  = w_gi[3]
                       | (w_pi[3] & w_gi[2])
                       | (w_pi[3] & w_pi[2] & w_gi[1])
                       | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
        assign w_gprop = &w_pi;

        assign w_gc[i+1]  = w_ggen | (w_gprop & w_cin);
        assign w_c[4*i]   = w_cin;
        assign w_c[4*i+1] = w_gi[0] | (w_pi[0] & w_cin);
        assign w_c[4*i+2] = w_gi[1] | (w_pi[1] & w_gi[0]) | (w_pi[1] & w_pi[0] & w_cin);
        assign w_c[4*i+3] = w_gi[2] | (w_pi[2] & w_gi[1]) | (w_pi[2] & w_pi[1] & w_gi[0])
                          | (w_pi[2] & w_pi[1] & w_pi[0] & w_cin);
    end

    assign w_s      = w_p ^ w_c;
    assign diff     = w_s[N-1:0];
    assign borrow   = ~w_gc[NG];
    assign w_unused = ^w_s;

endmodule

`default_nettype wire

// File: rtl/seq_divider16.sv
// ============================================================================
// seq_divider16 : multi-cycle unsigned restoring divider, valid/ready ports.
//                 Optional divide-by-zero fast path/flag: SEQDIV_DBZ_ERR_EN
// Revision      : 1.0
// ============================================================================
`default_nettype none

module seq_divider16
    import seqdiv_pkg::*;
#(
    parameter int W = SEQDIV_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
`ifdef SEQDIV_DBZ_ERR_EN
    ,
    output logic         err
`endif
);

    localparam int CW = $clog2(W);

    seqdiv_state_t state_q;
    seqdiv_state_t state_d;

    logic [W-1:0]  q_q;
    logic [W-1:0]  q_d;
    logic [W:0]    r_q;
    logic [W:0]    r_d;
    logic [W-1:0]  d_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  quot_q;
    logic [W-1:0]  rem_q;

    logic [W:0]    w_t;
    logic [W:0]    w_diff;
    logic          w_borrow;
    logic          w_accept;
    logic          w_dbz;
    logic          w_last;
    logic          w_unused;

    assign w_accept = in_valid && (state_q == IDLE);
    assign w_last   = (state_q == RUN) && (cnt_q == '0);

`ifdef SEQDIV_DBZ_ERR_EN
    assign w_dbz = (divisor == '0);
`else
    assign w_dbz = 1'b0;
`endif

    assign w_t = {r_q[W-1:0], q_q[W-1]};

    sub_lookahead #(.N(W + 1)) u_sub (
        .a      (w_t),
        .b      ({1'b0, d_q}),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    assign q_d = {q_q[W-2:0], ~w_borrow};
    assign r_d = w_borrow ? w_t : w_diff;

    // Restored partial remainder is always below the divisor, so its top bit is never read.
    assign w_unused = r_q[W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = w_dbz ? DONE : RUN;
            RUN:     if (w_last)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            q_q   <= dividend;
            r_q   <= '0;
            d_q   <= divisor;
            cnt_q <= CW'(W - 1);
        end else if (state_q == RUN) begin
            q_q   <= q_d;
            r_q   <= r_d;
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quot_q <= '0;
            rem_q  <= '0;
        end else if (w_accept && w_dbz) begin
            quot_q <= '1;
            rem_q  <= dividend;
        end else if (w_last) begin
            quot_q <= q_d;
            rem_q  <= r_d[W-1:0];
        end
    end

`ifdef SEQDIV_DBZ_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (w_accept) begin
            err_q <= w_dbz;
        end
    end

    assign err = err_q;
`endif

    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider16.sv
// ============================================================================
// tb_seq_divider16 : directed self-checking bench for seq_divider16
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_seq_divider16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
`ifdef SEQDIV_DBZ_ERR_EN
    logic        err;
    localparam int DBZ_LAT = 0;
`else
    localparam int DBZ_LAT = 16;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int n;

    seq_divider16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef SEQDIV_DBZ_ERR_EN
        ,
        .err       (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
    endtask

    // Latency is counted in rising edges after the acceptance edge.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] eq, input logic [15:0] er,
                         input int elat, input int stall);
        int k;
        wait_ready();
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        in_valid = 1'b0;
`ifdef SEQDIV_DBZ_ERR_EN
        check("err_on_accept", {31'd0, err}, {31'd0, (b == 16'd0)});
`endif
        k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        check("latency", k, elat);
        check("quotient", {16'd0, quotient}, {16'd0, eq});
        check("remainder", {16'd0, remainder}, {16'd0, er});
        for (int i = 0; i < stall; i++) begin
            tick();
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_quotient", {16'd0, quotient}, {16'd0, eq});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_after_take", {31'd0, out_valid}, 32'd0);
        check("ready_after_take", {31'd0, in_ready}, 32'd1);
        check("quotient_kept_idle", {16'd0, quotient}, {16'd0, eq});
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] rq;
        logic [15:0] rr;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;
        tick();
        tick();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {16'd0, remainder}, 32'd0);
`ifdef SEQDIV_DBZ_ERR_EN
        check("rst_err", {31'd0, err}, 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        do_op(16'd100, 16'd7, 16'd14, 16'd2, 16, 0);
        do_op(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 16, 1);
        do_op(16'd5, 16'd9, 16'd0, 16'd5, 16, 0);
        do_op(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16, 0);
        do_op(16'd1234, 16'd0, 16'hFFFF, 16'd1234, DBZ_LAT, 0);
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 16, 0);

        // Stall in DONE with stray in_valid pulses during RUN and DONE.
        wait_ready();
        in_valid = 1'b1;
        dividend = 16'd1000;
        divisor  = 16'd3;
        tick();
        dividend = 16'd7;
        divisor  = 16'd7;
        check("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid = (n < 6);
            tick();
            n++;
        end
        in_valid = 1'b0;
        check("stall_latency", n, 16);
        check("stall_quotient", {16'd0, quotient}, 32'd333);
        check("stall_remainder", {16'd0, remainder}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            check("stall_valid", {31'd0, out_valid}, 32'd1);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_q_stable", {16'd0, quotient}, 32'd333);
            check("stall_r_stable", {16'd0, remainder}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tick();
        tick();
        check("no_queue_valid", {31'd0, out_valid}, 32'd0);
        check("no_queue_ready", {31'd0, in_ready}, 32'd1);

        // Reset at step 8 of RUN.
        in_valid = 1'b1;
        dividend = 16'd50000;
        divisor  = 16'd123;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check("abort_quotient", {16'd0, quotient}, 32'd0);
        check("abort_remainder", {16'd0, remainder}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        do_op(16'd100, 16'd7, 16'd14, 16'd2, 16, 0);

        for (int j = 0; j < 200; j++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
            rq = (rb == 16'd0) ? 16'hFFFF : ra / rb;
            rr = (rb == 16'd0) ? ra : ra % rb;
            do_op(ra, rb, rq, rr, (rb == 16'd0) ? DBZ_LAT : 16, int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
